pipe_dmem: RTL and testbench

PIPE_DMEM -- requirements
Module: pipe_dmem

---
 rtl/pipe_mem_pkg.sv | 18 +
 rtl/pipe_dmem_array.sv | 25 ++
 rtl/pipe_dmem.sv | 144 ++++++++++++++
 tb/tb_pipe_dmem.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the pipelined data memory.
// The FSM state type is only used when PIPE_DMEM_WAIT_EN is defined.
package pipe_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of word-index bits needed to address a memory of the given depth.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_dmem_array.sv
// Word storage for pipe_dmem: one synchronous write port and one combinational read port.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_dmem.sv
// MEM-stage data memory with optional wait states (define PIPE_DMEM_WAIT_EN to enable them).
// Without the macro it is a zero-wait memory: write at the request edge, combinational read.
module pipe_dmem
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DMAddress,
  input  logic [31:0] DMWriteData,
  output logic [31:0] DMReadData,
  output logic        MemBusy,
  output logic        MisAlign
);

  localparam int AW = idx_width(DEPTH);

  logic [AW-1:0] req_idx;
  logic          req_active;
  logic          req_aligned;

  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [31:0]   arr_wdata;
  logic [AW-1:0] arr_raddr;
  logic [31:0]   arr_rdata;

  // Upper address bits wrap away; WAIT_CYCLES is irrelevant in the zero-wait build.
  logic unused_bits;
  assign unused_bits = ^{DMAddress[31:AW+2], 4'(WAIT_CYCLES)};

  assign req_idx     = DMAddress[AW+1:2];
  assign req_active  = MemRead | MemWrite;
  assign req_aligned = (DMAddress[1:0] == 2'b00);
  assign MisAlign    = req_active & ~req_aligned;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

`ifdef PIPE_DMEM_WAIT_EN

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy;
  logic              commit_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    busy      = 1'b0;
    commit_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_active && req_aligned) begin
          busy    = 1'b1;
          idx_d   = req_idx;
          data_d  = DMWriteData;
          wr_d    = MemWrite;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          if (wr_q) begin
            commit_wr = 1'b1;
          end else begin
            rdata_d = arr_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // Always drop back to IDLE so a request held through DONE is a new access.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset must win over a request that is already on the inputs.
  assign MemBusy    = busy & ~rst;
  assign arr_we     = commit_wr & ~rst;
  assign arr_waddr  = idx_q;
  assign arr_wdata  = data_q;
  assign arr_raddr  = idx_q;
  assign DMReadData = rdata_q;

`else

  assign MemBusy    = 1'b0;
  assign arr_we     = MemWrite & req_aligned & ~rst;
  assign arr_waddr  = req_idx;
  assign arr_wdata  = DMWriteData;
  assign arr_raddr  = req_idx;
  assign DMReadData = (MemRead && req_aligned && !rst) ? arr_rdata : 32'h0;

`endif

endmodule

// File: tb/tb_pipe_dmem.sv
// Self-checking bench for pipe_dmem; works with or without PIPE_DMEM_WAIT_EN.
// Expected values come from a word-array model indexed by (addr/4) mod DEPTH.
module tb_pipe_dmem;

  localparam int DEPTH = 64;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] DMAddress;
  logic [31:0] DMWriteData;
  logic [31:0] DMReadData;
  logic        MemBusy;
  logic        MisAlign;

  always #5 clk = ~clk;

  pipe_dmem #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .DMAddress   (DMAddress),
    .DMWriteData (DMWriteData),
    .DMReadData  (DMReadData),
    .MemBusy     (MemBusy),
    .MisAlign    (MisAlign)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rdata = 32'h0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 32'd4) % 32'(DEPTH));
  endfunction

  // One complete access; returns the read data seen once the access is over.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit perturb,
                        output logic [31:0] got);
    bit act;
    bit aligned;
    int i;
    int n;
    act     = rd | wr;
    aligned = (addr[1:0] == 2'b00);
    i       = widx(addr);
    n       = 0;
    @(negedge clk);
    MemRead     = rd;
    MemWrite    = wr;
    DMAddress   = addr;
    DMWriteData = data;
    #1;
    chk("misalign", {31'b0, MisAlign}, {31'b0, act && !aligned});
`ifdef PIPE_DMEM_WAIT_EN
    if (!act || !aligned) begin
      chk("noacc_busy", {31'b0, MemBusy}, 32'h0);
      chk("noacc_rdata", DMReadData, last_rdata);
      @(posedge clk);
      #1;
      chk("noacc_busy_after_edge", {31'b0, MemBusy}, 32'h0);
      chk("noacc_rdata_after_edge", DMReadData, last_rdata);
    end else begin
      while (MemBusy === 1'b1 && n < 20) begin
        chk("rdata_hold_while_busy", DMReadData, last_rdata);
        n++;
        if (perturb && n == 2) begin
          MemRead     = 1'($urandom % 2);
          MemWrite    = 1'($urandom % 2);
          DMAddress   = $urandom;
          DMWriteData = $urandom;
        end
        @(negedge clk);
        #1;
      end
      chk("busy_cycles", n, WC + 1);
      if (wr) model[i] = data;
      else    last_rdata = model[i];
      chk("done_rdata", DMReadData, last_rdata);
    end
    got      = DMReadData;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
`else
    chk("busy_zero", {31'b0, MemBusy}, 32'h0);
    if (!(rd && wr)) chk("comb_rdata", DMReadData, (rd && aligned) ? model[i] : 32'h0);
    got = DMReadData;
    if (wr && aligned) model[i] = data;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
`endif
    $display("txn rd=%0d wr=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h perturb=%0d",
             rd, wr, addr, data, got, perturb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    bit rd, wr, pert;
    int hi, lo;

    vecs[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[1]  = '{1, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 0, 32'h0000_0006, 32'h0,         0, 32'h0};
    vecs[3]  = '{0, 1, 32'h0000_0000, 32'h1,         0, 32'h0};
    vecs[4]  = '{0, 1, 32'(DEPTH * 4), 32'h2,        0, 32'h0};
    vecs[5]  = '{1, 0, 32'h0000_0000, 32'h0,         1, 32'h2};
    vecs[6]  = '{1, 1, 32'h0000_0008, 32'h7,         0, 32'h0};
    vecs[7]  = '{1, 0, 32'h0000_0008, 32'h0,         1, 32'h7};
    vecs[8]  = '{0, 1, 32'h0000_0003, 32'h99,        0, 32'h0};
    vecs[9]  = '{1, 0, 32'hFFFF_FF00, 32'h0,         1, 32'h2};
    vecs[10] = '{1, 0, 32'h0000_0004, 32'h0,         1, 32'hA000_0001};

    rst         = 1'b1;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    DMAddress   = 32'h0;
    DMWriteData = 32'h0;
    repeat (2) @(negedge clk);
    MemRead   = 1'b1;
    DMAddress = 32'h4;
    #1;
    chk("reset_busy", {31'b0, MemBusy}, 32'h0);
    chk("reset_rdata", DMReadData, 32'h0);
    chk("reset_misalign", {31'b0, MisAlign}, 32'h0);
    MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      access(0, 1, 32'(k * 4), 32'hA000_0000 + 32'(k), 0, got);
    end

    for (int k = 0; k < 11; k++) begin
      access(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].data, 0, got);
      if (vecs[k].chk_rd) chk($sformatf("table_rd[%0d]", k), got, vecs[k].exp_rd);
    end

`ifdef PIPE_DMEM_WAIT_EN
    // Request held across DONE: two distinct accesses, each WC+1 busy cycles.
    @(negedge clk);
    MemWrite    = 1'b1;
    DMAddress   = 32'h14;
    DMWriteData = 32'h44;
    hi = 0;
    lo = 0;
    for (int k = 0; k < 2 * (WC + 2); k++) begin
      #1;
      if (MemBusy === 1'b1) hi++;
      else lo++;
      if (k == 2 * (WC + 2) - 1) MemWrite = 1'b0;
      @(negedge clk);
    end
    chk("held_busy_cycles", hi, 2 * (WC + 1));
    chk("held_idle_cycles", lo, 2);
    model[5] = 32'h44;
    access(1, 0, 32'h14, 32'h0, 0, got);
    chk("held_readback", got, 32'h44);

    // Reset in the middle of a write: nothing reaches the array.
    @(negedge clk);
    MemWrite    = 1'b1;
    DMAddress   = 32'h20;
    DMWriteData = 32'h55;
    #1;
    chk("rst_seq_busy_start", {31'b0, MemBusy}, 32'h1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    MemWrite = 1'b0;
    #1;
    chk("rst_seq_busy", {31'b0, MemBusy}, 32'h0);
    chk("rst_seq_rdata", DMReadData, 32'h0);
    #1;
    rst        = 1'b0;
    last_rdata = 32'h0;
    access(1, 0, 32'h20, 32'h0, 0, got);
    chk("rst_seq_prior_contents", got, 32'hA000_0008);
`else
    // Held write with changing data: each edge commits, the last value wins.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      MemWrite    = 1'b1;
      DMAddress   = 32'h14;
      DMWriteData = 32'h11 * 32'(k + 1);
      #1;
      chk("held_busy_zero", {31'b0, MemBusy}, 32'h0);
    end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    model[5] = 32'h33;
    access(1, 0, 32'h14, 32'h0, 0, got);
    chk("held_readback", got, 32'h33);
`endif

    for (int k = 0; k < 200; k++) begin
      rd   = 1'($urandom % 2);
      wr   = 1'($urandom % 2);
      if (!rd && !wr) rd = 1'b1;
      addr = $urandom;
      if ($urandom % 4 != 0) addr[1:0] = 2'b00;
      pert = 1'($urandom % 2);
      access(rd, wr, addr, $urandom, pert, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
